// File: rtl/cpu_defs.sv
// cpu_defs: constants and types shared by the fetch front-end
package cpu_defs;
   localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
   localparam int          HZ_STALLF = 4;
   localparam int          HZ_STALLD = 5;
   localparam int          HZ_FLUSHE = 6;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/flopenrc.sv
// flopenrc: width-parameterised register with enable and synchronous clear
module flopenrc #(
   parameter int         W    = 32,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      q <= rst ? INIT : clr ? '0 : en ? d : q;
endmodule

// File: rtl/fetch_pipe_regs.sv
// fetch_pipe_regs: PC register, instruction-fetch handshake, IF/ID and ID/EX registers
module fetch_pipe_regs
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter int          E_W      = 160
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [0:8]     hazard_control,
   input  logic [31:0]    pc_next,
   output logic           inst_req,
   output logic [31:0]    inst_addr,
   input  logic           inst_addr_ok,
   input  logic           inst_data_ok,
   input  logic [31:0]    inst_rdata,
   output logic [31:0]    pcF,
   output logic [31:0]    instrD,
   output logic [31:0]    pcD,
   output logic           validD,
   input  logic [E_W-1:0] bundleD,
   output logic [E_W-1:0] bundleE,
   output logic           fetch_busy
);
   fetch_state_t state_q, state_d;
   logic [31:0]  hold_q, hold_d;
   logic [31:0]  fetched;
   logic [64:0]  ifid_q;
   logic         stall_f, stall_d, flush_e, fetch_done;
   logic         unused_hz;

   assign stall_f    = hazard_control[HZ_STALLF];
   assign stall_d    = hazard_control[HZ_STALLD];
   assign flush_e    = hazard_control[HZ_FLUSHE];
   assign unused_hz  = ^{hazard_control[0:3], hazard_control[7:8]};
   assign fetch_done = (state_q == WAIT && inst_data_ok) || state_q == HOLD;
   assign fetched    = state_q == HOLD ? hold_q : inst_rdata;
   assign inst_req   = state_q == REQ;
   assign inst_addr  = pcF;
   assign fetch_busy = !fetch_done;
   assign {instrD, pcD, validD} = ifid_q;

   // a response arriving under stall is parked so it is never dropped
   always_comb begin
      hold_d  = (state_q == WAIT && inst_data_ok && stall_d) ? inst_rdata : hold_q;
      state_d = state_q == REQ  ? (inst_addr_ok ? WAIT : REQ) :
                state_q == WAIT ? (inst_data_ok ? (stall_d ? HOLD : REQ) : WAIT) :
                                  (stall_d ? HOLD : REQ);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= REQ;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   flopenrc #(.W(32), .INIT(RESET_PC)) pc_reg (
      .clk(clk), .rst(!resetn), .en(fetch_done && !stall_f), .clr(1'b0),
      .d(pc_next), .q(pcF)
   );

   flopenrc #(.W(65)) ifid_reg (
      .clk(clk), .rst(!resetn), .en(!stall_d), .clr(1'b0),
      .d(fetch_done ? {fetched, pcF, 1'b1} : {NOP_INSTR, pcF, 1'b0}), .q(ifid_q)
   );

   flopenrc #(.W(E_W)) idex_reg (
      .clk(clk), .rst(!resetn), .en(1'b1), .clr(flush_e),
      .d(bundleD), .q(bundleE)
   );
endmodule

// File: tb/tb_fetch_pipe_regs.sv
// tb_fetch_pipe_regs: vector table, corner sequences and randomized model check
module tb_fetch_pipe_regs;
   localparam logic [31:0] BFC = 32'hBFC0_0000;
   localparam int E_W = 160;

   logic           clk = 1'b0;
   logic           resetn;
   logic [0:8]     hazard_control;
   logic [31:0]    pc_next, inst_addr, inst_rdata, pcF, instrD, pcD;
   logic           inst_req, inst_addr_ok, inst_data_ok, validD, fetch_busy;
   logic [E_W-1:0] bundleD, bundleE;

   int checks = 0;
   int failures = 0;

   fetch_pipe_regs dut (
      .clk(clk), .resetn(resetn), .hazard_control(hazard_control), .pc_next(pc_next),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .pcF(pcF), .instrD(instrD),
      .pcD(pcD), .validD(validD), .bundleD(bundleD), .bundleE(bundleE), .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rn, aok, dok, st, fl, bo, pre;
      logic [31:0] rd, pn;
      logic        req, busy;
      logic [31:0] pc, ins, pcd;
      logic        vd, be;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string n, input logic [E_W-1:0] a, input logic [E_W-1:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic drive(input logic rn, input logic aok, input logic dok, input logic st,
                        input logic fl, input logic [31:0] rd, input logic [31:0] pn,
                        input logic [E_W-1:0] bd);
      resetn = rn;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      hazard_control = 9'($urandom);
      hazard_control[4] = st;
      hazard_control[5] = st;
      hazard_control[6] = fl;
      inst_rdata = rd;
      pc_next = pn;
      bundleD = bd;
   endtask

   function automatic logic [E_W-1:0] rnd_bundle();
      logic [E_W-1:0] b;
      for (int k = 0; k < E_W / 32; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   // behavioural model: fetch progress as "accepted" and "data held" flags
   logic           m_acc, m_hd, m_vd;
   logic [31:0]    m_buf, m_pc, m_ins, m_pcd;
   logic [E_W-1:0] m_be;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tv[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0, 32'h0,        1'b1,1'b1, BFC,     32'h0,        32'h0,   1'b0,1'b0};
      tv[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,        1'b1,1'b1, BFC,     32'h0,        32'h0,   1'b0,1'b0};
      tv[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, BFC+4,        1'b1,1'b1, BFC,     32'h0,        BFC,     1'b0,1'b0};
      tv[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h24080001, BFC+4, 1'b0,1'b0, BFC+4,   32'h24080001, BFC,     1'b1,1'b0};
      tv[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 32'h0, BFC+8,        1'b1,1'b1, BFC+4,   32'h0,        BFC+4,   1'b0,1'b0};
      tv[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0, BFC+8,        1'b1,1'b1, BFC+4,   32'h0,        BFC+4,   1'b0,1'b1};
      tv[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, BFC+8,        1'b1,1'b1, BFC+4,   32'h0,        BFC+4,   1'b0,1'b0};
      tv[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, BFC+8,        1'b1,1'b1, BFC+4,   32'h0,        BFC+4,   1'b0,1'b0};
      tv[8]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'h8C090000, BFC+8, 1'b0,1'b0, BFC+4,   32'h0,        BFC+4,   1'b0,1'b0};
      tv[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, BFC+8,        1'b0,1'b0, BFC+4,   32'h0,        BFC+4,   1'b0,1'b0};
      tv[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, BFC+8,        1'b0,1'b0, BFC+8,   32'h8C090000, BFC+4,   1'b1,1'b0};
      tv[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, BFC+12,       1'b1,1'b1, BFC+8,   32'h0,        BFC+8,   1'b0,1'b0};

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(tv[i].rn, tv[i].aok, tv[i].dok, tv[i].st, tv[i].fl, tv[i].rd, tv[i].pn,
               tv[i].bo ? '1 : '0);
         #1;
         if (tv[i].pre) begin
            chk($sformatf("v%0d inst_req", i), E_W'(inst_req), E_W'(tv[i].req));
            chk($sformatf("v%0d fetch_busy", i), E_W'(fetch_busy), E_W'(tv[i].busy));
            if (tv[i].req) chk($sformatf("v%0d inst_addr", i), E_W'(inst_addr), E_W'(tv[i].pc));
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pcF", i), E_W'(pcF), E_W'(tv[i].pc));
         chk($sformatf("v%0d instrD", i), E_W'(instrD), E_W'(tv[i].ins));
         chk($sformatf("v%0d pcD", i), E_W'(pcD), E_W'(tv[i].pcd));
         chk($sformatf("v%0d validD", i), E_W'(validD), E_W'(tv[i].vd));
         chk($sformatf("v%0d bundleE", i), bundleE, tv[i].be ? '1 : '0);
      end

      // reset while a request is outstanding
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1234_5678, '1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h1234_5678, '1);
      @(posedge clk);
      #1;
      chk("midrst pcF", E_W'(pcF), E_W'(BFC));
      chk("midrst validD", E_W'(validD), E_W'(1'b0));
      chk("midrst pcD", E_W'(pcD), E_W'(32'h0));
      chk("midrst bundleE", bundleE, '0);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, '0);
      #1;
      chk("midrst inst_req", E_W'(inst_req), E_W'(1'b1));
      chk("midrst fetch_busy", E_W'(fetch_busy), E_W'(1'b1));
      @(posedge clk);
      #1;
      chk("midrst no capture", E_W'(validD), E_W'(1'b0));
      chk("midrst pcF held", E_W'(pcF), E_W'(BFC));

      // randomized run against the model
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      m_acc = 0; m_hd = 0; m_buf = 0; m_pc = BFC; m_ins = 0; m_pcd = 0; m_vd = 0; m_be = '0;
      for (int c = 0; c < 1500; c++) begin
         logic st, fl, aok, dok, done, req;
         logic [31:0] rd, pn, got;
         logic [E_W-1:0] bd;
         @(negedge clk);
         req = !m_acc && !m_hd;
         st  = $urandom_range(0, 3) == 0;
         fl  = $urandom_range(0, 3) == 0;
         aok = req && $urandom_range(0, 2) == 0;
         dok = m_acc && $urandom_range(0, 2) == 0;
         rd  = $urandom;
         pn  = $urandom;
         bd  = rnd_bundle();
         drive(1'b1, aok, dok, st, fl, rd, pn, bd);
         done = (m_acc && dok) || m_hd;
         got  = m_hd ? m_buf : rd;
         #1;
         chk("rnd inst_req", E_W'(inst_req), E_W'(req));
         chk("rnd fetch_busy", E_W'(fetch_busy), E_W'(!done));
         chk("rnd inst_addr", E_W'(inst_addr), E_W'(m_pc));
         @(posedge clk);
         if (!st) begin
            m_ins = done ? got : 32'h0;
            m_pcd = m_pc;
            m_vd  = done;
         end
         if (m_acc && dok) begin
            m_acc = 0;
            if (st) begin m_hd = 1; m_buf = rd; end
         end else if (m_hd && !st) m_hd = 0;
         if (aok) m_acc = 1;
         if (done && !st) m_pc = pn;
         m_be = fl ? '0 : bd;
         #1;
         chk("rnd pcF", E_W'(pcF), E_W'(m_pc));
         chk("rnd instrD", E_W'(instrD), E_W'(m_ins));
         chk("rnd pcD", E_W'(pcD), E_W'(m_pcd));
         chk("rnd validD", E_W'(validD), E_W'(m_vd));
         chk("rnd bundleE", bundleE, m_be);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_pipe_regs.md
Name: fetch_pipe_regs

Overview:
- Front-end register bank that receives and applies the stall/flush control word produced by the hazard unit.
- Owns the PC register, the sram-like instruction-fetch handshake, the IF/ID register and the ID/EX register.
- Applies stallF, stallD and flushE to the pipeline state.
- Raises fetch_busy when instruction memory has not returned, so the top level can freeze later stages.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value after reset.
- E_W, 160, width of the decode-to-execute control/data bundle.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- hazard_control  in  [0:8]  {forwardAE[0:1], forwardBE[2:3], stallF[4], stallD[5], flushE[6], forwardAD[7], forwardBD[8]}; only bits 4..6 are used
- pc_next  in  32  next PC chosen by the decode stage (pc+4 or branch target)
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address, equals pcF
- inst_addr_ok  in  1  memory accepted the request this cycle
- inst_data_ok  in  1  instruction data valid this cycle
- inst_rdata  in  32  instruction word
- pcF  out  32  current fetch PC
- instrD  out  32  IF/ID instruction
- pcD  out  32  IF/ID PC
- validD  out  1  IF/ID holds a real instruction, not a bubble
- bundleD  in  E_W  decode-stage outputs to be registered
- bundleE  out  E_W  ID/EX register contents
- fetch_busy  out  1  fetch not complete this cycle

Behaviour:
Reset (resetn=0 at a clock edge):
- pcF=RESET_PC, state=REQ.
- instrD=0, pcD=0, validD=0, bundleE=0, hold buffer=0.
- Instruction memory shares resetn, so no stale response can follow reset.

FSM states: REQ, WAIT, HOLD. Define fetch_done = (WAIT & inst_data_ok) | HOLD.

REQ:
- inst_req=1, inst_addr=pcF.
- inst_addr_ok=1 -> WAIT; else stay in REQ.
- inst_req must stay 1 with a stable inst_addr until accepted; stallF does not withdraw a pending request.

WAIT:
- inst_req=0.
- inst_data_ok=1 and stallD=0: IF/ID <= {inst_rdata, pcF, 1}; pcF <= pc_next; -> REQ.
- inst_data_ok=1 and stallD=1: hold buffer <= inst_rdata; -> HOLD. pcF unchanged.

HOLD:
- inst_req=0.
- stallD=0: IF/ID <= {buffer, pcF, 1}; pcF <= pc_next; -> REQ.
- stallD=1: stay in HOLD.

IF/ID register:
- stallD=1: hold its value.
- stallD=0 and !fetch_done: load a bubble {0, pcF, 0}.
- stallD=0 and fetch_done: load as in the WAIT/HOLD rules above.

PC update:
- pcF changes only when fetch_done & !stallD.
- stallF=1 blocks the pcF update. stallF and stallD are always equal in this design; if they ever differ, the register follows stallF for pcF and stallD for IF/ID.

fetch_busy:
- fetch_busy = !fetch_done (combinational).
- Asserted throughout REQ and in WAIT until inst_data_ok.

ID/EX register:
- flushE=1: bundleE <= 0 (flush has priority).
- Otherwise bundleE <= bundleD every cycle.
- ID/EX is never stalled by this block.

Simultaneous events:
- inst_addr_ok and inst_data_ok never occur in the same cycle for the same request (memory contract).
- In WAIT, inst_data_ok together with stallD=1 always captures the data into the hold buffer; an instruction is never dropped.

Latency and cycle rules:
- Minimum fetch is 2 cycles per instruction: REQ with addr_ok in the same cycle, then WAIT with data_ok the next cycle.
- pcF never advances without a completed fetch.
- The branch delay slot is always fetched.

Decomposition:
- Shared package cpu_defs:
  - RESET_PC
  - hazard_control bit indices: HZ_STALLF=4, HZ_STALLD=5, HZ_FLUSHE=6
  - NOP_INSTR=32'h0
  - FSM state encoding: fetch_state_t {REQ, WAIT, HOLD}
- One sub-module, flopenrc: a width-parameterised register with enable and synchronous clear. Instantiate it for pcF, IF/ID and ID/EX.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> pcF=BFC00000, inst_req=1, validD=0, bundleE=0, fetch_busy=1.
- Zero-wait fetch: addr_ok in cycle 1, data_ok with rdata=24080001 in cycle 2, stallD=0 -> instrD=24080001, pcD=BFC00000, validD=1, pcF=pc_next=BFC00004.
- Stall while waiting: addr_ok delayed 3 cycles -> inst_req held high with inst_addr stable; IF/ID loads a bubble each cycle; fetch_busy=1.
- Data under stall: data_ok (rdata=8C090000) while stallD=1 for 2 cycles -> state HOLD, IF/ID and pcF unchanged; stallD drops -> instrD=8C090000 the next cycle.
- flushE: bundleD=all-ones with flushE=1 -> bundleE=0 next cycle; flushE=0 -> bundleE=all-ones.
- Reset mid-operation: resetn=0 while in WAIT -> next state REQ, pcF=BFC00000, IF/ID cleared, no instruction is captured afterwards.
